// File: rtl/uart_bus_master.sv
// UART command bridge: decodes 'W'/'R' byte commands into single 32-bit bus
// transfers and returns an acknowledge or the read data over the UART.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        tx_busy_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_byte_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  we_o,
  input  logic [31:0] rdata_i,
  output logic        busy_o
);

  // state | meaning
  // IDLE  | waiting for a command byte
  // ADDR  | collecting 4 address bytes, LSB first
  // DATA  | collecting 4 write-data bytes, LSB first
  // BUS   | bus request outstanding until ready_i
  // RESP  | sending 'K' or the 4 read-data bytes
  // ERR   | sending '?' for an unknown command
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, ERR} state_e;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  we_q, we_d;
  logic        valid_q, valid_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [1:0]  guard_q, guard_d;
  logic [31:0] tmo_q, tmo_d;
  logic        tx_ok;

  // guard_q covers the pulse cycle plus two cycles of UART busy-rise latency
  assign tx_ok = (guard_q == 2'd0) && !tx_busy_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    valid_d    = valid_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    guard_d    = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    tmo_d      = 32'd0;

    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (rx_valid_i) begin
          if (rx_byte_i == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = ADDR;
          end else if (rx_byte_i == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = ADDR;
          end else begin
            state_d = ERR;
          end
        end
      end
      ADDR: begin
        if (rx_valid_i) begin
          addr_d[{cnt_q, 3'b000} +: 8] = rx_byte_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = DATA;
            end else begin
              state_d = BUS;
              valid_d = 1'b1;
              we_d    = 4'h0;
            end
          end
        end else if (tmo_q == TIMEOUT_CYCLES) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      DATA: begin
        if (rx_valid_i) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = rx_byte_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = BUS;
            valid_d = 1'b1;
            we_d    = 4'hF;
          end
        end else if (tmo_q == TIMEOUT_CYCLES) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      BUS: begin
        // no timeout here: a silent slave holds the bridge until reset
        if (ready_i) begin
          valid_d = 1'b0;
          we_d    = 4'h0;
          if (!is_wr_q) rdata_d = rdata_i;
          state_d = RESP;
          cnt_d   = 2'd0;
        end
      end
      RESP: begin
        if (tx_ok) begin
          tx_start_d = 1'b1;
          guard_d    = 2'd3;
          tx_byte_d  = is_wr_q ? RSP_ACK : rdata_q[{cnt_q, 3'b000} +: 8];
          cnt_d      = cnt_q + 2'd1;
          if (is_wr_q || cnt_q == 2'd3) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
      end
      ERR: begin
        if (tx_ok) begin
          tx_start_d = 1'b1;
          guard_d    = 2'd3;
          tx_byte_d  = RSP_ERR;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      is_wr_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      we_q       <= 4'h0;
      valid_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'd0;
      guard_q    <= 2'd0;
      tmo_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      valid_q    <= valid_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      guard_q    <= guard_d;
      tmo_q      <= tmo_d;
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_byte_o  = tx_byte_q;
  assign valid_o    = valid_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign we_o       = we_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a UART transmitter model and a
// memory-mapped slave model with programmable wait states.
module tb_uart_bus_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_byte_i = 8'd0;
  logic        tx_busy_i = 1'b0;
  logic        tx_start_o;
  logic [7:0]  tx_byte_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  we_o;
  logic [31:0] rdata_i = 32'd0;
  logic        busy_o;

  uart_bus_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid_i(rx_valid_i), .rx_byte_i(rx_byte_i),
    .tx_busy_i(tx_busy_i), .tx_start_o(tx_start_o), .tx_byte_o(tx_byte_o),
    .valid_o(valid_o), .ready_i(ready_i), .addr_o(addr_o),
    .wdata_o(wdata_o), .we_o(we_o), .rdata_i(rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // UART transmitter model: busy for 8 cycles after each start pulse
  logic [7:0] tx_log[$];
  int busy_cnt = 0;
  int busy_err = 0;
  int pulse_err = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (tx_start_o) begin
      tx_log.push_back(tx_byte_o);
      if (tx_busy_i) busy_err++;
      if (prev_start) pulse_err++;
      busy_cnt = 8;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_start = tx_start_o;
    tx_busy_i = (busy_cnt != 0);
  end

  // Slave model: ready_i after slave_wait extra cycles, checks request stability
  int slave_wait = 0;
  int cur_len = 0;
  int last_len = 0;
  int txn_cnt = 0;
  int stab_err = 0;
  logic [31:0] rec_addr, rec_wdata;
  logic [3:0]  rec_we;
  always @(negedge clk) begin
    if (valid_o) begin
      if (cur_len == 0) begin
        rec_addr = addr_o; rec_wdata = wdata_o; rec_we = we_o;
      end else if (addr_o !== rec_addr || wdata_o !== rec_wdata || we_o !== rec_we) begin
        stab_err++;
      end
      ready_i = (cur_len == slave_wait);
      cur_len++;
    end else begin
      ready_i = 1'b0;
      if (cur_len != 0) begin
        last_len = cur_len; txn_cnt++; cur_len = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(8'(a >> (8 * i)));
    for (int i = 0; i < 4; i++) send_byte(8'(d >> (8 * i)));
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'(a >> (8 * i)));
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL %s_idle_timeout: busy_o=%b required 0", name, busy_o);
    else n_pass++;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_o); else n_pass++;
    n_total++; if (we_o !== 4'h0) $display("FAIL rst_we: got %h want 0", we_o); else n_pass++;
    n_total++; if (addr_o !== 32'd0) $display("FAIL rst_addr: got %h want 0", addr_o); else n_pass++;
    n_total++; if (wdata_o !== 32'd0) $display("FAIL rst_wdata: got %h want 0", wdata_o); else n_pass++;
    n_total++; if (tx_start_o !== 1'b0) $display("FAIL rst_tx_start: got %b want 0", tx_start_o); else n_pass++;
    n_total++; if (tx_byte_o !== 8'd0) $display("FAIL rst_tx_byte: got %h want 0", tx_byte_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_write();
    int t0 = txn_cnt;
    tx_log.delete();
    slave_wait = 0;
    send_write(32'h0000_0010, 32'hDEAD_BEEF);
    wait_idle("write");
    n_total++; if (txn_cnt - t0 !== 1) $display("FAIL wr_txn_count: got %0d want 1", txn_cnt - t0); else n_pass++;
    n_total++; if (rec_addr !== 32'h10) $display("FAIL wr_addr: got %h want 00000010", rec_addr); else n_pass++;
    n_total++; if (rec_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata: got %h want deadbeef", rec_wdata); else n_pass++;
    n_total++; if (rec_we !== 4'hF) $display("FAIL wr_we: got %h want f", rec_we); else n_pass++;
    n_total++; if (last_len !== 1) $display("FAIL wr_valid_len: got %0d want 1", last_len); else n_pass++;
    n_total++; if (tx_log.size() !== 1) $display("FAIL wr_tx_count: got %0d want 1", tx_log.size()); else n_pass++;
    n_total++; if ((tx_log.size() > 0 ? tx_log[0] : 8'hxx) !== 8'h4B) $display("FAIL wr_tx_byte: got %h want 4b", tx_log.size() > 0 ? tx_log[0] : 8'hxx); else n_pass++;
  endtask

  task automatic test_read();
    logic [31:0] rd = 32'h1234_5678;
    logic [7:0] got, exp;
    tx_log.delete();
    slave_wait = 1;
    rdata_i = rd;
    send_read(32'h0000_0004);
    wait_idle("read");
    n_total++; if (rec_we !== 4'h0) $display("FAIL rd_we: got %h want 0", rec_we); else n_pass++;
    n_total++; if (rec_addr !== 32'h4) $display("FAIL rd_addr: got %h want 00000004", rec_addr); else n_pass++;
    n_total++; if (last_len !== 2) $display("FAIL rd_valid_len: got %0d want 2", last_len); else n_pass++;
    n_total++; if (tx_log.size() !== 4) $display("FAIL rd_tx_count: got %0d want 4", tx_log.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp = 8'(rd >> (8 * i));
      got = (tx_log.size() > i) ? tx_log[i] : 8'hxx;
      n_total++; if (got !== exp) $display("FAIL rd_tx_byte%0d: got %h want %h", i, got, exp); else n_pass++;
    end
    rdata_i = 32'd0;
  endtask

  task automatic test_bad_cmd();
    int t0 = txn_cnt;
    tx_log.delete();
    send_byte(8'h41);
    wait_idle("bad");
    n_total++; if (tx_log.size() !== 1) $display("FAIL bad_tx_count: got %0d want 1", tx_log.size()); else n_pass++;
    n_total++; if ((tx_log.size() > 0 ? tx_log[0] : 8'hxx) !== 8'h3F) $display("FAIL bad_tx_byte: got %h want 3f", tx_log.size() > 0 ? tx_log[0] : 8'hxx); else n_pass++;
    n_total++; if (txn_cnt !== t0) $display("FAIL bad_no_bus: got %0d txns want 0", txn_cnt - t0); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL bad_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_timeout();
    int t0 = txn_cnt;
    tx_log.delete();
    slave_wait = 0;
    send_byte(8'h57);
    send_byte(8'h10);
    repeat (99) @(negedge clk);
    n_total++; if (busy_o !== 1'b1) $display("FAIL tmo_before_limit: busy_o=%b want 1", busy_o); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (busy_o !== 1'b0) $display("FAIL tmo_at_limit: busy_o=%b want 0", busy_o); else n_pass++;
    repeat (20) @(negedge clk);
    n_total++; if (txn_cnt !== t0) $display("FAIL tmo_no_bus: got %0d txns want 0", txn_cnt - t0); else n_pass++;
    n_total++; if (tx_log.size() !== 0) $display("FAIL tmo_no_tx: got %0d bytes want 0", tx_log.size()); else n_pass++;
    send_write(32'h0000_0020, 32'h0102_0304);
    wait_idle("tmo_follow");
    n_total++; if (rec_addr !== 32'h20) $display("FAIL tmo_follow_addr: got %h want 00000020", rec_addr); else n_pass++;
    n_total++; if (rec_wdata !== 32'h01020304) $display("FAIL tmo_follow_wdata: got %h want 01020304", rec_wdata); else n_pass++;
    n_total++; if (tx_log.size() !== 1 || tx_log[0] !== 8'h4B) $display("FAIL tmo_follow_tx: got %0d bytes, want one 4b", tx_log.size()); else n_pass++;
  endtask

  task automatic test_wait_state();
    int s0 = stab_err;
    tx_log.delete();
    slave_wait = 5;
    send_write(32'h0000_0100, 32'hCAFE_F00D);
    wait_idle("wait");
    n_total++; if (last_len !== 6) $display("FAIL ws_valid_len: got %0d want 6", last_len); else n_pass++;
    n_total++; if (stab_err !== s0) $display("FAIL ws_stable: got %0d unstable cycles want 0", stab_err - s0); else n_pass++;
    n_total++; if (rec_addr !== 32'h100 || rec_wdata !== 32'hCAFEF00D) $display("FAIL ws_req: got %h/%h want 00000100/cafef00d", rec_addr, rec_wdata); else n_pass++;
    n_total++; if (valid_o !== 1'b0) $display("FAIL ws_valid_after: got %b want 0", valid_o); else n_pass++;
    n_total++; if (tx_log.size() !== 1) $display("FAIL ws_tx_count: got %0d want 1", tx_log.size()); else n_pass++;
  endtask

  task automatic test_reset_in_bus();
    int k = 0;
    tx_log.delete();
    slave_wait = 100000;
    send_read(32'h0000_0040);
    while (!valid_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_total++; if (valid_o !== 1'b1) $display("FAIL rib_enter_bus: valid_o=%b want 1", valid_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (valid_o !== 1'b0) $display("FAIL rib_async_valid: got %b want 0", valid_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rib_async_busy: got %b want 0", busy_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    slave_wait = 0;
    repeat (50) @(negedge clk);
    n_total++; if (tx_log.size() !== 0) $display("FAIL rib_no_tx: got %0d bytes want 0", tx_log.size()); else n_pass++;
    send_write(32'h0000_0044, 32'h55AA_55AA);
    wait_idle("rib_follow");
    n_total++; if (rec_addr !== 32'h44 || rec_wdata !== 32'h55AA55AA || rec_we !== 4'hF) $display("FAIL rib_follow_req: got %h/%h/%h want 00000044/55aa55aa/f", rec_addr, rec_wdata, rec_we); else n_pass++;
    n_total++; if (tx_log.size() !== 1 || tx_log[0] !== 8'h4B) $display("FAIL rib_follow_tx: got %0d bytes, want one 4b", tx_log.size()); else n_pass++;
  endtask

  task automatic test_tx_protocol();
    n_total++; if (busy_err !== 0) $display("FAIL tx_start_while_busy: got %0d want 0", busy_err); else n_pass++;
    n_total++; if (pulse_err !== 0) $display("FAIL tx_start_width: got %0d long pulses want 0", pulse_err); else n_pass++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_write();
    test_read();
    test_bad_cmd();
    test_timeout();
    test_wait_state();
    test_reset_in_bus();
    test_tx_protocol();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
